// File: rtl/fetch_inst_queue_if.sv
// Handshake bundle between preIF, the fetch queue, the icache response path and decode.
interface fetch_inst_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned INFO_W = 39
);
    logic                             in_valid;
    logic                             in_allowin;
    logic [31:0]                      in_pc;
    logic [INFO_W-1:0]                in_info;
    logic                             in_has_req;
    logic                             out_valid;
    logic                             out_allowin;
    logic [31:0]                      out_pc;
    logic [INFO_W-1:0]                out_info;
    logic [31:0]                      out_inst;
    logic                             cache_data_ok;
    logic [31:0]                      cache_rdata;
    logic                             flush;
    logic [$clog2(DEPTH+1)-1:0]       count;
    logic [$clog2(2*DEPTH+1)-1:0]     discard_cnt;

    modport master (
        output in_valid, in_pc, in_info, in_has_req, out_allowin,
        output cache_data_ok, cache_rdata, flush,
        input  in_allowin, out_valid, out_pc, out_info, out_inst, count, discard_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_info, in_has_req, out_allowin,
        input  cache_data_ok, cache_rdata, flush,
        output in_allowin, out_valid, out_pc, out_info, out_inst, count, discard_cnt
    );
endinterface

// File: rtl/fetch_inst_queue.sv
// Fetch-stage queue: holds in-flight fetches, matches in-order icache responses to them and
// delivers completed entries to decode in program order; flushed requests are counted and dropped.
module fetch_inst_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned INFO_W = 39
) (
    input logic                clk,
    input logic                reset,
    fetch_inst_queue_if.slave  q_if
);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned DiscW = $clog2(2 * DEPTH + 1);

    logic [31:0]       pc_q   [DEPTH];
    logic [31:0]       pc_d   [DEPTH];
    logic [INFO_W-1:0] info_q [DEPTH];
    logic [INFO_W-1:0] info_d [DEPTH];
    logic [31:0]       inst_q [DEPTH];
    logic [31:0]       inst_d [DEPTH];
    logic [DEPTH-1:0]  has_req_q, has_req_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [DiscW-1:0]  discard_q, discard_d;

    logic              full, push, pop;
    logic              found, resp_hit, head_bypass;
    logic [PtrW-1:0]   tgt, scan_idx;
    logic [CntW-1:0]   pending;

    always_comb begin
        full     = (count_q == CntW'(DEPTH));
        push     = q_if.in_valid && !full;
        found    = 1'b0;
        tgt      = '0;
        scan_idx = '0;
        pending  = '0;
        // Oldest live entry still waiting for its instruction is the response target.
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PtrW'(i);
            if (CntW'(i) < count_q && has_req_q[scan_idx] && !done_q[scan_idx]) begin
                pending = pending + CntW'(1);
                if (!found) begin
                    found = 1'b1;
                    tgt   = scan_idx;
                end
            end
        end
        resp_hit    = q_if.cache_data_ok && (discard_q == '0) && found;
        head_bypass = resp_hit && (tgt == head_q);

        q_if.in_allowin  = !full;
        q_if.out_valid   = !q_if.flush && (count_q != '0) && (done_q[head_q] || head_bypass);
        q_if.count       = count_q;
        q_if.discard_cnt = discard_q;
        q_if.out_pc      = '0;
        q_if.out_info    = '0;
        q_if.out_inst    = '0;
        if (q_if.out_valid) begin
            q_if.out_pc   = pc_q[head_q];
            q_if.out_info = info_q[head_q];
            if (has_req_q[head_q]) begin
                q_if.out_inst = head_bypass ? q_if.cache_rdata : inst_q[head_q];
            end
        end
        pop = q_if.out_valid && q_if.out_allowin;

        pc_d      = pc_q;
        info_d    = info_q;
        inst_d    = inst_q;
        has_req_d = has_req_q;
        done_d    = done_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        discard_d = discard_q;

        if (q_if.flush) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            // A response only retires an owed request if something was waiting for it.
            discard_d = discard_q + DiscW'(pending) + DiscW'(push && q_if.in_has_req)
                      - DiscW'(q_if.cache_data_ok && ((discard_q != '0) || found));
        end else begin
            if (q_if.cache_data_ok && (discard_q != '0)) begin
                discard_d = discard_q - DiscW'(1);
            end else if (resp_hit) begin
                inst_d[tgt] = q_if.cache_rdata;
                done_d[tgt] = 1'b1;
            end
            if (push) begin
                pc_d[tail_q]      = q_if.in_pc;
                info_d[tail_q]    = q_if.in_info;
                inst_d[tail_q]    = '0;
                has_req_d[tail_q] = q_if.in_has_req;
                done_d[tail_q]    = !q_if.in_has_req;
                tail_d            = tail_q + PtrW'(1);
            end
            if (pop) begin
                head_d = head_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                info_q[i] <= '0;
                inst_q[i] <= '0;
            end
            has_req_q <= '0;
            done_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            info_q    <= info_d;
            inst_q    <= inst_d;
            has_req_q <= has_req_d;
            done_q    <= done_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            discard_q <= discard_d;
        end
    end
endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed bench for fetch_inst_queue: single fetch, fill/stall, flush discard, exception entry, reset.
module tb_fetch_inst_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    fetch_inst_queue_if #(.DEPTH(4), .INFO_W(39)) fq ();

    fetch_inst_queue #(.DEPTH(4), .INFO_W(39)) dut (
        .clk   (clk),
        .reset (reset),
        .q_if  (fq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fq.in_valid      = 1'b0;
        fq.in_pc         = '0;
        fq.in_info       = '0;
        fq.in_has_req    = 1'b0;
        fq.out_allowin   = 1'b0;
        fq.cache_data_ok = 1'b0;
        fq.cache_rdata   = '0;
        fq.flush         = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic has_req, input logic [38:0] info);
        fq.in_valid   = 1'b1;
        fq.in_pc      = pc;
        fq.in_has_req = has_req;
        fq.in_info    = info;
        tick();
        fq.in_valid   = 1'b0;
        fq.in_has_req = 1'b0;
        fq.in_info    = '0;
    endtask

    task automatic resp(input logic [31:0] data);
        fq.cache_data_ok = 1'b1;
        fq.cache_rdata   = data;
        tick();
        fq.cache_data_ok = 1'b0;
    endtask

    initial begin
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_count", 64'(fq.count), 64'd0);
        chk("rst_discard", 64'(fq.discard_cnt), 64'd0);
        chk("rst_out_valid", 64'(fq.out_valid), 64'd0);
        chk("rst_in_allowin", 64'(fq.in_allowin), 64'd1);
        chk("rst_out_pc", 64'(fq.out_pc), 64'd0);
        chk("rst_out_info", 64'(fq.out_info), 64'd0);
        chk("rst_out_inst", 64'(fq.out_inst), 64'd0);

        // Single fetch with same-cycle bypass of the response.
        tick();
        push(32'hBFC0_0000, 1'b1, '0);
        chk("single_count", 64'(fq.count), 64'd1);
        fq.cache_data_ok = 1'b1;
        fq.cache_rdata   = 32'h2408_0001;
        fq.out_allowin   = 1'b1;
        #1;
        chk("single_out_valid", 64'(fq.out_valid), 64'd1);
        chk("single_out_inst", 64'(fq.out_inst), 64'h2408_0001);
        chk("single_out_pc", 64'(fq.out_pc), 64'hBFC0_0000);
        tick();
        idle();
        #1;
        chk("single_pop_count", 64'(fq.count), 64'd0);
        chk("single_pop_valid", 64'(fq.out_valid), 64'd0);

        // Fill to full with decode stalled, store four responses, then drain.
        for (int k = 0; k < 4; k++) push(32'h0000_1000 + 32'(4 * k), 1'b1, '0);
        chk("fill_in_allowin", 64'(fq.in_allowin), 64'd0);
        chk("fill_count", 64'(fq.count), 64'd4);
        chk("fill_no_valid", 64'(fq.out_valid), 64'd0);
        for (int k = 0; k < 4; k++) resp(32'h11 * 32'(k + 1));
        chk("fill_stored_valid", 64'(fq.out_valid), 64'd1);
        chk("fill_stored_count", 64'(fq.count), 64'd4);
        fq.out_allowin = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_valid", 64'(fq.out_valid), 64'd1);
            chk("drain_pc", 64'(fq.out_pc), 64'h1000 + 64'(4 * k));
            chk("drain_inst", 64'(fq.out_inst), 64'h11 * 64'(k + 1));
            tick();
        end
        fq.out_allowin = 1'b0;
        #1;
        chk("drain_count", 64'(fq.count), 64'd0);
        chk("drain_in_allowin", 64'(fq.in_allowin), 64'd1);

        // Flush with three outstanding requests; new entry gets the fourth response.
        for (int k = 0; k < 3; k++) push(32'h0000_2000 + 32'(4 * k), 1'b1, '0);
        fq.flush = 1'b1;
        tick();
        fq.flush = 1'b0;
        #1;
        chk("flush3_discard", 64'(fq.discard_cnt), 64'd3);
        chk("flush3_count", 64'(fq.count), 64'd0);
        push(32'hBFC0_0380, 1'b1, '0);
        fq.cache_data_ok = 1'b1;
        fq.cache_rdata   = 32'hA;
        #1;
        chk("flush3_drop_valid", 64'(fq.out_valid), 64'd0);
        tick();
        fq.cache_data_ok = 1'b0;
        #1;
        chk("flush3_discard_a", 64'(fq.discard_cnt), 64'd2);
        resp(32'hB);
        resp(32'hC);
        chk("flush3_discard_c", 64'(fq.discard_cnt), 64'd0);
        chk("flush3_count_c", 64'(fq.count), 64'd1);
        fq.cache_data_ok = 1'b1;
        fq.cache_rdata   = 32'hD;
        fq.out_allowin   = 1'b1;
        #1;
        chk("flush3_d_valid", 64'(fq.out_valid), 64'd1);
        chk("flush3_d_inst", 64'(fq.out_inst), 64'hD);
        chk("flush3_d_pc", 64'(fq.out_pc), 64'hBFC0_0380);
        tick();
        idle();
        #1;
        chk("flush3_end_count", 64'(fq.count), 64'd0);

        // Flush and response in the same cycle with two pending.
        push(32'h0000_4000, 1'b1, '0);
        push(32'h0000_4004, 1'b1, '0);
        fq.flush         = 1'b1;
        fq.cache_data_ok = 1'b1;
        fq.cache_rdata   = 32'h55;
        #1;
        chk("flush_ok_valid", 64'(fq.out_valid), 64'd0);
        tick();
        idle();
        #1;
        chk("flush_ok_discard", 64'(fq.discard_cnt), 64'd1);
        chk("flush_ok_count", 64'(fq.count), 64'd0);
        resp(32'h66);
        chk("flush_ok_drained", 64'(fq.discard_cnt), 64'd0);

        // Flush and push in the same cycle with nothing pending.
        fq.flush      = 1'b1;
        fq.in_valid   = 1'b1;
        fq.in_has_req = 1'b1;
        fq.in_pc      = 32'h0000_5000;
        tick();
        idle();
        #1;
        chk("flush_push_discard", 64'(fq.discard_cnt), 64'd1);
        chk("flush_push_count", 64'(fq.count), 64'd0);
        resp(32'h77);
        chk("flush_push_drained", 64'(fq.discard_cnt), 64'd0);
        chk("flush_push_empty", 64'(fq.count), 64'd0);

        // Exception entry waits behind a pending fetch, then pops with info intact.
        push(32'h0000_3000, 1'b1, '0);
        push(32'h0000_3004, 1'b0, 39'h55_1234_5678);
        fq.out_allowin = 1'b1;
        #1;
        chk("exc_blocked", 64'(fq.out_valid), 64'd0);
        tick();
        chk("exc_count", 64'(fq.count), 64'd2);
        fq.cache_data_ok = 1'b1;
        fq.cache_rdata   = 32'h0000_0077;
        #1;
        chk("exc_first_valid", 64'(fq.out_valid), 64'd1);
        chk("exc_first_inst", 64'(fq.out_inst), 64'h77);
        chk("exc_first_pc", 64'(fq.out_pc), 64'h3000);
        tick();
        fq.cache_data_ok = 1'b0;
        #1;
        chk("exc_second_valid", 64'(fq.out_valid), 64'd1);
        chk("exc_second_inst", 64'(fq.out_inst), 64'd0);
        chk("exc_second_pc", 64'(fq.out_pc), 64'h3004);
        chk("exc_second_info", 64'(fq.out_info), 64'h55_1234_5678);
        tick();
        idle();
        #1;
        chk("exc_end_count", 64'(fq.count), 64'd0);

        // Reset mid-operation clears entries and the discard counter.
        push(32'h0000_6000, 1'b1, '0);
        push(32'h0000_6004, 1'b1, '0);
        fq.flush = 1'b1;
        tick();
        fq.flush = 1'b0;
        for (int k = 0; k < 3; k++) push(32'h0000_7000 + 32'(4 * k), 1'b1, '0);
        chk("pre_rst_discard", 64'(fq.discard_cnt), 64'd2);
        chk("pre_rst_count", 64'(fq.count), 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_count", 64'(fq.count), 64'd0);
        chk("mid_rst_discard", 64'(fq.discard_cnt), 64'd0);
        chk("mid_rst_out_valid", 64'(fq.out_valid), 64'd0);
        chk("mid_rst_in_allowin", 64'(fq.in_allowin), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
